// File: rtl/mem_word_display_sequencer_pkg.sv
// rtl/mem_word_display_sequencer_pkg.sv - shared state encoding and blank segment pattern
package mem_word_display_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] BLANK_SEG = 8'hFF;

endpackage

// File: rtl/SevenSeg.sv
// rtl/SevenSeg.sv - hex nibble to active-low seven-segment pattern, decimal point off
module SevenSeg (
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    case (hex_i)
      4'h0: seg_o = 8'hC0;
      4'h1: seg_o = 8'hF9;
      4'h2: seg_o = 8'hA4;
      4'h3: seg_o = 8'hB0;
      4'h4: seg_o = 8'h99;
      4'h5: seg_o = 8'h92;
      4'h6: seg_o = 8'h82;
      4'h7: seg_o = 8'hF8;
      4'h8: seg_o = 8'h80;
      4'h9: seg_o = 8'h90;
      4'hA: seg_o = 8'h88;
      4'hB: seg_o = 8'h83;
      4'hC: seg_o = 8'hC6;
      4'hD: seg_o = 8'hA1;
      4'hE: seg_o = 8'h86;
      4'hF: seg_o = 8'h8E;
      default: seg_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - power-of-two word FIFO with combinational head output
module word_fifo #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_word_display_sequencer.sv
// rtl/mem_word_display_sequencer.sv - buffers incoming words and shows each on HEX3..HEX0 for a dwell, then a blank gap
module mem_word_display_sequencer
  import mem_word_display_sequencer_pkg::*;
#(
  parameter int WORD_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DWELL_CYCLES = 25000000,
  parameter int BLANK_CYCLES = 2500000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              HOLD,
  output logic [7:0]        HEX0,
  output logic [7:0]        HEX1,
  output logic [7:0]        HEX2,
  output logic [7:0]        HEX3,
  output logic              SHOWING
);

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0] disp_q, disp_d;
  logic [WORD_W-1:0] head;
  logic              full, empty, pop;
  logic [7:0]        seg [4];

  word_fifo #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .push_i  (IN_VALID && IN_READY),
    .pop_i   (pop),
    .data_i  (IN_DATA),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign IN_READY = !full && !RESET;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1; disp_d = head; cnt_d = '0; state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!HOLD) begin
          if (cnt_q != DWELL_LAST) begin
            cnt_d = cnt_q + 32'd1;
          end else if (BLANK_CYCLES > 0) begin
            cnt_d = '0; state_d = ST_GAP;
          end else if (!empty) begin
            pop = 1'b1; disp_d = head; cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!HOLD) begin
          if (cnt_q != BLANK_LAST) begin
            cnt_d = cnt_q + 32'd1;
          end else if (!empty) begin
            pop = 1'b1; disp_d = head; cnt_d = '0; state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_digit
    SevenSeg u_seg (.hex_i(disp_q[4*g +: 4]), .seg_o(seg[g]));
  end

  assign SHOWING = (state_q == ST_SHOW);
  assign HEX0    = SHOWING ? seg[0] : BLANK_SEG;
  assign HEX1    = SHOWING ? seg[1] : BLANK_SEG;
  assign HEX2    = SHOWING ? seg[2] : BLANK_SEG;
  assign HEX3    = SHOWING ? seg[3] : BLANK_SEG;

endmodule

// File: tb/tb_mem_word_display_sequencer.sv
// tb/tb_mem_word_display_sequencer.sv - reference-model bench for the word display sequencer, gap and no-gap builds
module tb_mem_word_display_sequencer;

  localparam int DW    = 8;
  localparam int BL    = 2;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_SHOW = 1, P_GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, hold;
  logic        ready_a, showing_a, ready_b, showing_b;
  logic [7:0]  h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;

  int checks = 0;
  int failures = 0;

  // model: buffered words, current word, phase and cycles remaining in it
  logic [15:0] m_buf [2][DEPTH];
  int          m_head [2];
  int          m_cnt [2];
  int          m_phase [2];
  int          m_rem [2];
  logic [15:0] m_cur [2];

  always #5 clk = ~clk;

  mem_word_display_sequencer #(.WORD_W(16), .FIFO_DEPTH(DEPTH), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut_a (
    .CLOCK_50(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(ready_a),
    .HOLD(hold), .HEX0(h0a), .HEX1(h1a), .HEX2(h2a), .HEX3(h3a), .SHOWING(showing_a));

  mem_word_display_sequencer #(.WORD_W(16), .FIFO_DEPTH(DEPTH), .DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut_b (
    .CLOCK_50(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(ready_b),
    .HOLD(hold), .HEX0(h0b), .HEX1(h1b), .HEX2(h2b), .HEX3(h3b), .SHOWING(showing_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic logic [31:0] exp_hex(input int k);
    if (m_phase[k] != P_SHOW) return 32'hFFFF_FFFF;
    return {seg_of(m_cur[k][15:12]), seg_of(m_cur[k][11:8]), seg_of(m_cur[k][7:4]), seg_of(m_cur[k][3:0])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0; m_cnt[k] = 0; m_phase[k] = P_IDLE; m_rem[k] = 0; m_cur[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input int blank);
    logic do_push;
    logic take;
    do_push = in_valid && (m_cnt[k] < DEPTH);
    take = 1'b0;
    case (m_phase[k])
      P_IDLE: take = (m_cnt[k] > 0);
      P_SHOW: if (!hold) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          if (blank > 0) begin m_phase[k] = P_GAP; m_rem[k] = blank; end
          else if (m_cnt[k] > 0) take = 1'b1;
          else m_phase[k] = P_IDLE;
        end
      end
      default: if (!hold) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          if (m_cnt[k] > 0) take = 1'b1;
          else m_phase[k] = P_IDLE;
        end
      end
    endcase
    if (take) begin
      m_cur[k] = m_buf[k][m_head[k]];
      m_head[k] = (m_head[k] + 1) % DEPTH;
      m_cnt[k]--;
      m_phase[k] = P_SHOW;
      m_rem[k] = DW;
    end
    if (do_push) begin
      m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] = in_data;
      m_cnt[k]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, BL);
      model_step(1, 0);
    end
  end

  always @(negedge clk) begin
    check("ready_a", 32'(ready_a), 32'(!rst && m_cnt[0] < DEPTH));
    check("showing_a", 32'(showing_a), 32'(m_phase[0] == P_SHOW));
    check("hex_a", {h3a, h2a, h1a, h0a}, exp_hex(0));
    check("ready_b", 32'(ready_b), 32'(!rst && m_cnt[1] < DEPTH));
    check("showing_b", 32'(showing_b), 32'(m_phase[1] == P_SHOW));
    check("hex_b", {h3b, h2b, h1b, h0b}, exp_hex(1));
  end

  // Caller is at a negedge; returns one negedge after the word was taken by dut_a.
  task automatic push_word(input logic [15:0] w);
    int n;
    n = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    push_word(16'h1A2B);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);

    for (int i = 1; i <= 6; i++) push_word(16'(i));
    in_valid = 1'b0;
    repeat (70) @(negedge clk);

    push_word(16'hBEEF);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    hold = 1'b1;
    in_valid = 1'b1; in_data = 16'h1111;
    @(negedge clk);
    in_data = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    repeat (40) @(negedge clk);

    repeat (300) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) == 0);
      in_data = 16'($urandom);
      hold = ($urandom_range(0, 9) == 0);
    end
    in_valid = 1'b0; hold = 1'b0;
    repeat (120) @(negedge clk);

    push_word(16'hC0DE);
    push_word(16'h4567);
    push_word(16'h89AB);
    in_valid = 1'b0;
    n = 0;
    while (!showing_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("show_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_hex_a", {h3a, h2a, h1a, h0a}, 32'hFFFF_FFFF);
    check("async_showing_a", 32'(showing_a), 32'd0);
    check("async_ready_a", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
